rst_seq_ctrl: RTL and testbench



---
 rtl/rst_seq_pkg.sv | 18 +
 rtl/rst_seq_delay_cnt.sv | 39 +++
 rtl/rst_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_rst_seq_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared types and limits for the reset sequencer.
// Rev 1.0
`default_nettype none

package rst_seq_pkg;

  localparam int MaxDomains = 16;
  localparam int IdxWidth   = $clog2(MaxDomains);

  typedef enum logic [1:0] {
    RELEASE = 2'd0,
    RUN     = 2'd1,
    ASSERT  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/rst_seq_delay_cnt.sv
// rst_seq_delay_cnt: loadable up-counter with clear and terminal-count pulse.
// Rev 1.0
`default_nettype none

module rst_seq_delay_cnt #(
  parameter int DelayCycles = 16,
  parameter int CntWidth    = $clog2(DelayCycles + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                clr_i,
  input  logic                load_i,
  input  logic [CntWidth-1:0] load_val_i,
  output logic                tc_o
);

  localparam logic [CntWidth-1:0] TermCnt = CntWidth'(DelayCycles - 1);

  logic [CntWidth-1:0] cnt;

  // Terminal count self-clears the counter, so it never wraps past TermCnt.
  assign tc_o = en_i && !clr_i && !load_i && (cnt == TermCnt);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (clr_i) begin
      cnt <= '0;
    end else if (load_i) begin
      cnt <= load_val_i;
    end else if (en_i) begin
      cnt <= (cnt == TermCnt) ? '0 : cnt + CntWidth'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: releases reset domains in ascending order, re-sequences on SW request.
// Rev 1.0
`default_nettype none

module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NumDomains  = 4,
  parameter int DelayCycles = 16,
  parameter int CntWidth    = $clog2(DelayCycles + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  test_mode_i,
  input  logic                  sw_rst_req_i,
  output logic                  sw_rst_ack_o,
  output logic [NumDomains-1:0] domain_rst_no,
  output logic                  seq_done_o,
  output logic                  busy_o
);

  if (NumDomains < 1 || NumDomains > MaxDomains) begin : g_bad_num_domains
    $error("rst_seq_ctrl: NumDomains must be in 1..%0d", MaxDomains);
  end
  if (DelayCycles < 1) begin : g_bad_delay
    $error("rst_seq_ctrl: DelayCycles must be >= 1");
  end

  localparam logic [NumDomains-1:0] OneBit  = NumDomains'(1);
  localparam logic [IdxWidth-1:0]   LastIdx = IdxWidth'(NumDomains - 1);

  state_e                state;
  logic [IdxWidth-1:0]   idx;
  logic [NumDomains-1:0] rel_q;
  logic                  ack_pend;
  logic                  tc;
  logic                  cnt_en;
  logic                  cnt_clr;
  logic [IdxWidth-1:0]   idx_m1;
  logic [NumDomains-1:0] idx_bit;
  logic [NumDomains-1:0] idx_m1_bit;
  logic [NumDomains-1:0] last_bit;

  assign idx_m1     = idx - IdxWidth'(1);
  assign idx_bit    = OneBit << idx;
  assign idx_m1_bit = OneBit << idx_m1;
  assign last_bit   = OneBit << LastIdx;

  // Counter idles cleared in RUN so every sequence starts from zero.
  assign cnt_en  = (state != RUN);
  assign cnt_clr = (state == RUN);

  rst_seq_delay_cnt #(
    .DelayCycles (DelayCycles),
    .CntWidth    (CntWidth)
  ) u_delay_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (cnt_en),
    .clr_i      (cnt_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .tc_o       (tc)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= RELEASE;
      idx          <= '0;
      rel_q        <= '0;
      ack_pend     <= 1'b0;
      sw_rst_ack_o <= 1'b0;
      seq_done_o   <= 1'b0;
      busy_o       <= 1'b1;
    end else begin
      sw_rst_ack_o <= 1'b0;
      case (state)
        RELEASE: begin
          if (tc) begin
            rel_q <= rel_q | idx_bit;
            if (idx == LastIdx) begin
              state      <= RUN;
              seq_done_o <= 1'b1;
              busy_o     <= 1'b0;
              if (ack_pend) begin
                sw_rst_ack_o <= 1'b1;
                ack_pend     <= 1'b0;
              end
            end else begin
              idx <= idx + IdxWidth'(1);
            end
          end
        end
        RUN: begin
          // A request held across the ack cycle is not seen until the cycle after.
          if (sw_rst_req_i && !sw_rst_ack_o) begin
            state      <= ASSERT;
            idx        <= LastIdx;
            rel_q      <= rel_q & ~last_bit;
            ack_pend   <= 1'b1;
            seq_done_o <= 1'b0;
            busy_o     <= 1'b1;
          end
        end
        ASSERT: begin
          if (tc) begin
            if (idx == '0) begin
              state <= RELEASE;
            end else begin
              idx   <= idx_m1;
              rel_q <= rel_q & ~idx_m1_bit;
            end
          end
        end
        default: begin
          state      <= RELEASE;
          idx        <= '0;
          rel_q      <= '0;
          seq_done_o <= 1'b0;
          busy_o     <= 1'b1;
        end
      endcase
    end
  end

  assign domain_rst_no = test_mode_i ? {NumDomains{rst_ni}} : rel_q;

endmodule

`default_nettype wire

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: directed scoreboard bench for rst_seq_ctrl (3 domains, delay 4).
// Rev 1.0
`default_nettype none

module tb_rst_seq_ctrl;

  localparam int ND = 3;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          test_mode_i;
  logic          sw_rst_req_i;
  logic          sw_rst_ack_o;
  logic [ND-1:0] domain_rst_no;
  logic          seq_done_o;
  logic          busy_o;

  rst_seq_ctrl #(
    .NumDomains  (ND),
    .DelayCycles (DC)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .test_mode_i   (test_mode_i),
    .sw_rst_req_i  (sw_rst_req_i),
    .sw_rst_ack_o  (sw_rst_ack_o),
    .domain_rst_no (domain_rst_no),
    .seq_done_o    (seq_done_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      tag;
    logic [5:0] val;  // {dom[2:0], done, busy, ack}
  } exp_t;

  exp_t q[$];
  int   tests  = 0;
  int   failed = 0;
  int   cycle  = 0;

  function automatic logic [5:0] obs();
    return {domain_rst_no, seq_done_o, busy_o, sw_rst_ack_o};
  endfunction

  task automatic chk(input string tag, input logic [5:0] o, input logic [5:0] e);
    tests++;
    assert (o === e) else begin
      failed++;
      $error("FAIL %s: observed dom=%b done=%b busy=%b ack=%b, expected dom=%b done=%b busy=%b ack=%b",
             tag, o[5:3], o[2], o[1], o[0], e[5:3], e[2], e[1], e[0]);
    end
  endtask

  task automatic push(input int c, input string t, input logic [2:0] d,
                      input logic done, input logic busy, input logic ack);
    exp_t e;
    e.cyc = c;
    e.tag = t;
    e.val = {d, done, busy, ack};
    q.push_back(e);
  endtask

  task automatic run_to(input int c);
    exp_t e;
    while (cycle < c) begin
      @(posedge clk);
      #1;
      cycle++;
      while (q.size() > 0 && q[0].cyc == cycle) begin
        e = q.pop_front();
        chk(e.tag, obs(), e.val);
      end
    end
  endtask

  task automatic push_power_on();
    push(3,  "po_pre_d0",  3'b000, 1'b0, 1'b1, 1'b0);
    push(4,  "po_d0",      3'b001, 1'b0, 1'b1, 1'b0);
    push(7,  "po_pre_d1",  3'b001, 1'b0, 1'b1, 1'b0);
    push(8,  "po_d1",      3'b011, 1'b0, 1'b1, 1'b0);
    push(11, "po_pre_d2",  3'b011, 1'b0, 1'b1, 1'b0);
    push(12, "po_done",    3'b111, 1'b1, 1'b0, 1'b0);
    push(13, "po_no_ack",  3'b111, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst_ni       = 1'b0;
    test_mode_i  = 1'b0;
    sw_rst_req_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", obs(), {3'b000, 1'b0, 1'b1, 1'b0});

    // Power-on with a request pulse during RELEASE that must be ignored.
    rst_ni = 1'b1;
    cycle  = 0;
    push_power_on();
    run_to(1);
    sw_rst_req_i = 1'b1;
    run_to(2);
    sw_rst_req_i = 1'b0;
    run_to(13);
    push(14, "run_idle", 3'b111, 1'b1, 1'b0, 1'b0);
    run_to(14);

    // SW reset with req dropped right after capture (T = 14).
    sw_rst_req_i = 1'b1;
    push(15, "sw_d2_low",   3'b011, 1'b0, 1'b1, 1'b0);
    push(18, "sw_hold_d2",  3'b011, 1'b0, 1'b1, 1'b0);
    push(19, "sw_d1_low",   3'b001, 1'b0, 1'b1, 1'b0);
    push(22, "sw_hold_d1",  3'b001, 1'b0, 1'b1, 1'b0);
    push(23, "sw_d0_low",   3'b000, 1'b0, 1'b1, 1'b0);
    push(30, "sw_pre_rel",  3'b000, 1'b0, 1'b1, 1'b0);
    push(31, "sw_rel_d0",   3'b001, 1'b0, 1'b1, 1'b0);
    push(35, "sw_rel_d1",   3'b011, 1'b0, 1'b1, 1'b0);
    push(38, "sw_busy_end", 3'b011, 1'b0, 1'b1, 1'b0);
    push(39, "sw_ack",      3'b111, 1'b1, 1'b0, 1'b1);
    push(40, "sw_ack_end",  3'b111, 1'b1, 1'b0, 1'b0);
    run_to(15);
    sw_rst_req_i = 1'b0;
    run_to(40);

    // Held req: ack at 65, no retrigger at 66, new ASSERT at 67.
    sw_rst_req_i = 1'b1;
    push(41, "held_start",   3'b011, 1'b0, 1'b1, 1'b0);
    push(65, "held_ack",     3'b111, 1'b1, 1'b0, 1'b1);
    push(66, "held_no_retr", 3'b111, 1'b1, 1'b0, 1'b0);
    push(67, "held_retrig",  3'b011, 1'b0, 1'b1, 1'b0);
    push(71, "held_d1_low",  3'b001, 1'b0, 1'b1, 1'b0);
    run_to(67);
    sw_rst_req_i = 1'b0;
    run_to(72);

    // Asynchronous reset in the middle of ASSERT.
    rst_ni = 1'b0;
    #1;
    chk("async_rst_now", obs(), {3'b000, 1'b0, 1'b1, 1'b0});
    repeat (2) @(posedge clk);
    #1;
    chk("async_rst_hold", obs(), {3'b000, 1'b0, 1'b1, 1'b0});
    assert (q.size() == 0) else begin
      tests++;
      failed++;
      $error("FAIL queue_drain: observed %0d pending, expected 0", q.size());
    end

    // Power-on again; no stale ack may appear.
    rst_ni = 1'b1;
    cycle  = 0;
    push_power_on();
    run_to(5);
    test_mode_i = 1'b1;
    #1;
    chk("tm_bypass_hi", obs(), {3'b111, 1'b0, 1'b1, 1'b0});
    test_mode_i = 1'b0;
    #1;
    chk("tm_restore", obs(), {3'b001, 1'b0, 1'b1, 1'b0});
    run_to(13);

    // Test mode tracks rst_ni combinationally.
    test_mode_i = 1'b1;
    rst_ni      = 1'b0;
    #1;
    chk("tm_rst_low", obs(), {3'b000, 1'b0, 1'b1, 1'b0});
    rst_ni = 1'b1;
    #1;
    chk("tm_rst_high", obs(), {3'b111, 1'b0, 1'b1, 1'b0});
    test_mode_i = 1'b0;
    #1;
    chk("tm_off_relq", obs(), {3'b000, 1'b0, 1'b1, 1'b0});

    tests++;
    assert (q.size() == 0) else begin
      failed++;
      $error("FAIL final_drain: observed %0d pending, expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
